bsg_mem_1rw_sync_req_ctrl: RTL and testbench



---
 rtl/bsg_mem_1rw_sync_req_ctrl.sv | 106 ++++++++++
 tb/tb_bsg_mem_1rw_sync_req_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_req_ctrl.sv
// Requester-side controller for a 1rw synchronous RAM: valid/ready requests in,
// RAM strobes out, and read data returned through a credit-checked response FIFO.
module bsg_mem_1rw_sync_req_ctrl #(
    parameter int width_p       = 8,
    parameter int els_p         = 16,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int resp_els_p    = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_and_o,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    input  logic [width_p-1:0]       mem_data_i,

    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     ready_and_i
);

    localparam int unsigned ptr_width_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
    // Wide enough for count + pending without wrapping.
    localparam int unsigned cnt_width_lp = $clog2(resp_els_p + 2);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(resp_els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(resp_els_p);

    if (resp_els_p < 2) begin : g_bad_depth
        $error("bsg_mem_1rw_sync_req_ctrl: resp_els_p must be >= 2");
    end

    logic [width_p-1:0]      fifo_mem_r [resp_els_p];
    logic [ptr_width_lp-1:0] wr_ptr_r, wr_ptr_n;
    logic [ptr_width_lp-1:0] rd_ptr_r, rd_ptr_n;
    logic [cnt_width_lp-1:0] count_r, count_n;
    logic [cnt_width_lp-1:0] credits_used;
    logic                    rd_pending_r;
    logic                    accept;
    logic                    rd_accept;
    logic                    enq;
    logic                    deq;

    // Every outstanding read owns a FIFO slot, so the gate depends on registered state only.
    assign credits_used = count_r + cnt_width_lp'(rd_pending_r);
    assign ready_and_o  = ~reset_i & (credits_used < full_cnt_lp);

    assign accept     = v_i & ready_and_o;
    assign rd_accept  = accept & ~w_i;
    assign mem_v_o    = accept;
    assign mem_w_o    = w_i;
    assign mem_addr_o = addr_i;
    assign mem_data_o = data_i;

    // Read data landing during reset belongs to a request being abandoned.
    assign enq    = rd_pending_r & ~reset_i;
    assign v_o    = (count_r != '0);
    assign deq    = v_o & ready_and_i;
    assign data_o = fifo_mem_r[rd_ptr_r];

    always_comb begin
        wr_ptr_n = wr_ptr_r;
        rd_ptr_n = rd_ptr_r;
        count_n  = count_r + cnt_width_lp'(enq) - cnt_width_lp'(deq);
        if (enq) begin
            wr_ptr_n = (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + ptr_width_lp'(1);
        end
        if (deq) begin
            rd_ptr_n = (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + ptr_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_pending_r <= 1'b0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
        end else begin
            rd_pending_r <= rd_accept;
            wr_ptr_r     <= wr_ptr_n;
            rd_ptr_r     <= rd_ptr_n;
            count_r      <= count_n;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_r.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_mem_r[wr_ptr_r] <= mem_data_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        enq |-> (count_r < full_cnt_lp));

    a_mem_v_known: assert property (@(posedge clk_i) disable iff (reset_i)
        !$isunknown(mem_v_o));

endmodule

// File: tb/tb_bsg_mem_1rw_sync_req_ctrl.sv
// Directed bench for bsg_mem_1rw_sync_req_ctrl: one instance with a 3-deep and
// one with a 2-deep response buffer, each backed by a behavioural 1rw RAM.
module tb_bsg_mem_1rw_sync_req_ctrl;

    typedef struct {
        int rst, v, w, a, d, r;
        int er, em, ev, ed;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset1, v1, w1, r1, rdy1, mv1, mw1, vo1;
    logic [3:0] a1, ma1;
    logic [7:0] d1, md1, mdi1, do1;
    logic       reset2, v2, w2, r2, rdy2, mv2, mw2, vo2;
    logic [3:0] a2, ma2;
    logic [7:0] d2, md2, mdi2, do2;

    logic [7:0] ram1 [16];
    logic [7:0] ram2 [16];

    int total = 0;
    int bad   = 0;

    bsg_mem_1rw_sync_req_ctrl #(.width_p(8), .els_p(16), .resp_els_p(3)) dut1 (
        .clk_i(clk), .reset_i(reset1),
        .v_i(v1), .w_i(w1), .addr_i(a1), .data_i(d1), .ready_and_o(rdy1),
        .mem_v_o(mv1), .mem_w_o(mw1), .mem_addr_o(ma1), .mem_data_o(md1), .mem_data_i(mdi1),
        .v_o(vo1), .data_o(do1), .ready_and_i(r1)
    );

    bsg_mem_1rw_sync_req_ctrl #(.width_p(8), .els_p(16), .resp_els_p(2)) dut2 (
        .clk_i(clk), .reset_i(reset2),
        .v_i(v2), .w_i(w2), .addr_i(a2), .data_i(d2), .ready_and_o(rdy2),
        .mem_v_o(mv2), .mem_w_o(mw2), .mem_addr_o(ma2), .mem_data_o(md2), .mem_data_i(mdi2),
        .v_o(vo2), .data_o(do2), .ready_and_i(r2)
    );

    always_ff @(posedge clk) begin
        if (mv1) begin
            if (mw1) ram1[ma1] <= md1;
            else     mdi1      <= ram1[ma1];
        end
        if (mv2) begin
            if (mw2) ram2[ma2] <= md2;
            else     mdi2      <= ram2[ma2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs sampled 3 units later.
    task automatic apply(input int sel, input string tag, input int n, input vec_t t);
        logic       rr, mm, vv;
        logic [7:0] dd;
        if (sel == 1) begin
            reset1 = t.rst[0]; v1 = t.v[0]; w1 = t.w[0]; a1 = 4'(t.a); d1 = 8'(t.d); r1 = t.r[0];
        end else begin
            reset2 = t.rst[0]; v2 = t.v[0]; w2 = t.w[0]; a2 = 4'(t.a); d2 = 8'(t.d); r2 = t.r[0];
        end
        #3;
        if (sel == 1) begin rr = rdy1; mm = mv1; vv = vo1; dd = do1; end
        else          begin rr = rdy2; mm = mv2; vv = vo2; dd = do2; end
        check($sformatf("%s[%0d].ready_and_o", tag, n), 32'(rr), 32'(t.er));
        check($sformatf("%s[%0d].mem_v_o", tag, n), 32'(mm), 32'(t.em));
        check($sformatf("%s[%0d].v_o", tag, n), 32'(vv), 32'(t.ev));
        if (t.ev != 0) check($sformatf("%s[%0d].data_o", tag, n), 32'(dd), 32'(t.ed));
        @(posedge clk);
        #1;
    endtask

    //               rst v w a  d     r er em ev ed
    vec_t t_wr_rd [5] = '{
        '{0, 1, 1, 5, 'hA5, 1, 1, 1, 0, 0},
        '{0, 1, 0, 5, 0,    1, 1, 1, 0, 0},
        '{0, 0, 0, 0, 0,    1, 1, 0, 0, 0},
        '{0, 0, 0, 0, 0,    1, 1, 0, 1, 'hA5},
        '{0, 0, 0, 0, 0,    1, 1, 0, 0, 0}
    };

    vec_t t_bp [13] = '{
        '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0},
        '{0, 1, 0, 1, 0, 0, 1, 1, 0, 0},
        '{0, 1, 0, 2, 0, 0, 1, 1, 1, 0},
        '{0, 1, 0, 3, 0, 0, 0, 0, 1, 0},
        '{0, 1, 0, 3, 0, 0, 0, 0, 1, 0},
        '{0, 1, 0, 3, 0, 0, 0, 0, 1, 0},
        '{0, 1, 0, 3, 0, 0, 0, 0, 1, 0},
        '{0, 1, 0, 3, 0, 1, 0, 0, 1, 0},
        '{0, 1, 0, 3, 0, 1, 1, 1, 1, 3},
        '{0, 1, 0, 4, 0, 1, 1, 1, 1, 6},
        '{0, 0, 0, 0, 0, 1, 1, 0, 1, 9},
        '{0, 0, 0, 0, 0, 1, 1, 0, 1, 12},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0}
    };

    vec_t t_wr_full [13] = '{
        '{0, 1, 0, 0, 0,    0, 1, 1, 0, 0},
        '{0, 1, 0, 1, 0,    0, 1, 1, 0, 0},
        '{0, 1, 0, 2, 0,    0, 1, 1, 1, 0},
        '{0, 1, 1, 9, 'h77, 0, 0, 0, 1, 0},
        '{0, 1, 1, 9, 'h77, 0, 0, 0, 1, 0},
        '{0, 1, 1, 9, 'h77, 1, 0, 0, 1, 0},
        '{0, 1, 1, 9, 'h77, 0, 1, 1, 1, 3},
        '{0, 0, 0, 0, 0,    1, 1, 0, 1, 3},
        '{0, 0, 0, 0, 0,    1, 1, 0, 1, 6},
        '{0, 1, 0, 9, 0,    1, 1, 1, 0, 0},
        '{0, 0, 0, 0, 0,    1, 1, 0, 0, 0},
        '{0, 0, 0, 0, 0,    1, 1, 0, 1, 'h77},
        '{0, 0, 0, 0, 0,    1, 1, 0, 0, 0}
    };

    vec_t t_depth2 [11] = '{
        '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0},
        '{0, 1, 0, 1, 0, 1, 1, 1, 0, 0},
        '{0, 1, 0, 2, 0, 1, 0, 0, 1, 1},
        '{0, 1, 0, 2, 0, 1, 1, 1, 1, 4},
        '{0, 1, 0, 3, 0, 1, 1, 1, 0, 0},
        '{0, 1, 0, 4, 0, 1, 0, 0, 1, 7},
        '{0, 1, 0, 4, 0, 1, 1, 1, 1, 10},
        '{0, 1, 0, 5, 0, 1, 1, 1, 0, 0},
        '{0, 0, 0, 0, 0, 1, 0, 0, 1, 13},
        '{0, 0, 0, 0, 0, 1, 1, 0, 1, 16},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0}
    };

    vec_t t_rst [9] = '{
        '{0, 1, 0, 7, 0, 1, 1, 1, 0, 0},
        '{1, 1, 0, 7, 0, 1, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0},
        '{0, 1, 0, 9, 0, 1, 1, 1, 0, 0},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0},
        '{0, 0, 0, 0, 0, 1, 1, 0, 1, 'h77},
        '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0}
    };

    initial begin
        vec_t wv;
        reset1 = 1'b1; v1 = 1'b1; w1 = 1'b0; a1 = '0; d1 = '0; r1 = 1'b1;
        reset2 = 1'b1; v2 = 1'b1; w2 = 1'b0; a2 = '0; d2 = '0; r2 = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check("reset.ready_and_o1", 32'(rdy1), 32'd0);
        check("reset.mem_v_o1", 32'(mv1), 32'd0);
        check("reset.v_o1", 32'(vo1), 32'd0);
        check("reset.ready_and_o2", 32'(rdy2), 32'd0);
        check("reset.mem_v_o2", 32'(mv2), 32'd0);
        check("reset.v_o2", 32'(vo2), 32'd0);
        @(posedge clk);
        #1;
        reset1 = 1'b0; v1 = 1'b0; reset2 = 1'b0; v2 = 1'b0;
        #3;
        check("post_reset.ready_and_o1", 32'(rdy1), 32'd1);
        check("post_reset.v_o1", 32'(vo1), 32'd0);
        check("post_reset.ready_and_o2", 32'(rdy2), 32'd1);
        check("post_reset.v_o2", 32'(vo2), 32'd0);
        @(posedge clk);
        #1;

        foreach (t_wr_rd[i]) apply(1, "wr_rd", i, t_wr_rd[i]);

        for (int i = 0; i < 8; i++) begin
            wv = '{0, 1, 1, i, 3 * i, 1, 1, 1, 0, 0};
            apply(1, "preload1", i, wv);
        end
        for (int i = 0; i < 6; i++) begin
            wv = '{0, 1, 1, i, 3 * i + 1, 1, 1, 1, 0, 0};
            apply(2, "preload2", i, wv);
        end
        wv = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        apply(2, "idle2", 0, wv);

        for (int i = 0; i < 12; i++) begin
            wv = '{0, (i < 8) ? 1 : 0, 0, (i < 8) ? i : 0, 0, 1,
                   1, (i < 8) ? 1 : 0, (i >= 2 && i < 10) ? 1 : 0, 3 * (i - 2)};
            apply(1, "stream", i, wv);
        end

        foreach (t_bp[i])      apply(1, "backpressure", i, t_bp[i]);
        foreach (t_wr_full[i]) apply(1, "write_full", i, t_wr_full[i]);
        foreach (t_depth2[i])  apply(2, "depth2", i, t_depth2[i]);
        foreach (t_rst[i])     apply(1, "mid_reset", i, t_rst[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
